// File: rtl/paillier_pkg.sv
// rtl/paillier_pkg.sv - shared defaults and types for the Paillier result collector
package paillier_pkg;

    localparam int DEFAULT_K = 128;
    localparam int DEFAULT_N = 32;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    typedef logic [DEFAULT_K-1:0] word_t;

endpackage

// File: rtl/paillier_result_collector_if.sv
// rtl/paillier_result_collector_if.sv - core-side capture stream and backpressured output stream
interface paillier_result_collector_if #(
    parameter int K = paillier_pkg::DEFAULT_K
);

    logic [K-1:0] in_data;
    logic         in_valid;
    logic [K-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  out_last
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid,
        output out_last
    );

endinterface

// File: rtl/paillier_word_bank.sv
// rtl/paillier_word_bank.sv - N x K register bank, one write port, one combinational read port, clear
module paillier_word_bank #(
    parameter int K = paillier_pkg::DEFAULT_K,
    parameter int N = paillier_pkg::DEFAULT_N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [$clog2(N)-1:0] wr_addr,
    input  logic [K-1:0]         wr_data,
    input  logic [$clog2(N)-1:0] rd_addr,
    output logic [K-1:0]         rd_data
);

    logic [K-1:0] mem [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/paillier_result_collector.sv
// rtl/paillier_result_collector.sv - ping-pong collector turning the core result stream into a framed stream
// Optional PAILLIER_COLLECT_MSW_FIRST_EN emits each result most-significant word first.
module paillier_result_collector
    import paillier_pkg::*;
#(
    parameter int K = paillier_pkg::DEFAULT_K,
    parameter int N = paillier_pkg::DEFAULT_N
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        err_clr,
    paillier_result_collector_if.slave  io,
    output logic                        busy,
    output logic                        overflow_err
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    bank_state_t   bst_q [2];
    bank_state_t   bst_d [2];
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          err_q, err_d;

    logic          wr_open, out_valid_i, rd_hs, rd_done, vacate;
    logic          wr_ok, wr_done, drop;
    logic [AW-1:0] rd_idx;
    logic [K-1:0]  rd_word [2];

    assign wr_open     = (bst_q[wr_bank_q] == EMPTY) || (bst_q[wr_bank_q] == FILLING);
    assign out_valid_i = (bst_q[rd_bank_q] == DRAINING);
    assign rd_hs       = out_valid_i && io.out_ready;
    assign rd_done     = rd_hs && (rd_ptr_q == LAST);
    // A bank whose final word is handed off this cycle is free at the edge, so a
    // word arriving for it is kept; this keeps sustained full-rate input lossless.
    assign vacate      = rd_done && (rd_bank_q == wr_bank_q);
    assign wr_ok       = io.in_valid && !flush && (wr_open || vacate);
    assign wr_done     = wr_ok && (wr_ptr_q == LAST);
    assign drop        = io.in_valid && !flush && !wr_ok;

`ifdef PAILLIER_COLLECT_MSW_FIRST_EN
    assign rd_idx = LAST - rd_ptr_q;
`else
    assign rd_idx = rd_ptr_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bst_q[0]  <= EMPTY;
            bst_q[1]  <= EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            bst_q     <= bst_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        bst_d     = bst_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_d     = err_q;

        if (flush) begin
            bst_d[0]  = EMPTY;
            bst_d[1]  = EMPTY;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end else begin
            // The other bank may start draining on the edge this one finishes, avoiding a bubble.
            for (int b = 0; b < 2; b++) begin
                if (rd_bank_q == 1'(b)) begin
                    if (bst_q[b] == FULL)  bst_d[b] = DRAINING;
                    else if (rd_done)      bst_d[b] = EMPTY;
                end else if (rd_done && bst_q[b] == FULL) begin
                    bst_d[b] = DRAINING;
                end
            end
            if (rd_hs)   rd_ptr_d  = rd_ptr_q + 1'b1;
            if (rd_done) rd_bank_d = ~rd_bank_q;
            if (wr_ok) begin
                bst_d[wr_bank_q] = wr_done ? FULL : FILLING;
                wr_ptr_d         = wr_ptr_q + 1'b1;
                if (wr_done) wr_bank_d = ~wr_bank_q;
            end
        end

        if (drop)         err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        paillier_word_bank #(.K(K), .N(N)) u_bank (
            .clk     (clk),
            .rst     (rst),
            .clr     (flush),
            .wr_en   (wr_ok && (wr_bank_q == 1'(g))),
            .wr_addr (wr_ptr_q),
            .wr_data (io.in_data),
            .rd_addr (rd_idx),
            .rd_data (rd_word[g])
        );
    end

    assign io.out_valid = out_valid_i;
    assign io.out_last  = out_valid_i && (rd_ptr_q == LAST);
    assign io.out_data  = rd_word[rd_bank_q];
    assign busy         = (bst_q[0] != EMPTY) || (bst_q[1] != EMPTY);
    assign overflow_err = err_q;

endmodule

// File: doc/paillier_result_collector.md
# paillier_result_collector

Downstream stage of the Paillier core that captures the word-serial result stream (N words of K bits, LSW first, valid-only and no backpressure) and turns it into a backpressured word stream with framing. It uses two N-word banks in ping-pong, so one result can drain while the next one fills. A consumer such as a DMA or host bridge can therefore stall without losing core output. Words that arrive while both banks are occupied are dropped and flagged.

## Interface
- K, 128, word width in bits
- N, 32, words per result (power of two, ≥2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear of both banks and pointers; error flag is not cleared
- in_data  in  K  result word from core (enc_out_data)
- in_valid  in  1  word qualifier (enc_out_valid); no ready is returned
- out_data  out  K  output word
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- out_last  out  1  high with the last word (index N-1) of a result
- busy  out  1  at least one bank is not EMPTY
- overflow_err  out  1  sticky; set when an in_valid word is dropped; cleared only by rst or err_clr
- err_clr  in  1  clears overflow_err

## Operation
- Each bank has a state: EMPTY, FILLING, FULL or DRAINING.
- Write side:
  - wr_bank selects the bank being written; wr_ptr is $clog2(N) bits.
  - On in_valid, if bank[wr_bank] is EMPTY or FILLING, store the word at wr_ptr and increment wr_ptr. The bank moves EMPTY→FILLING on the first word.
  - When wr_ptr == N-1 and in_valid, the bank goes FULL, wr_ptr wraps to 0 and wr_bank toggles.
  - If bank[wr_bank] is FULL or DRAINING on in_valid, the word is dropped, overflow_err is set and wr_ptr is unchanged.
- Read side:
  - rd_bank selects the bank being read; rd_ptr is $clog2(N) bits.
  - When bank[rd_bank] is FULL it enters DRAINING.
  - out_data = bank[rd_bank][rd_ptr] (combinational read of register storage). out_valid is high while DRAINING.
  - Each handshake increments rd_ptr.
  - The handshake at rd_ptr == N-1 (out_last high) sets the bank to EMPTY, wraps rd_ptr to 0 and toggles rd_bank.
- Simultaneous events:
  - A write completing bank A and a read completing bank B in the same cycle are both honoured.
  - err_clr and an overflow in the same cycle: the flag stays set (set wins).
- Flush: both banks go to EMPTY and all pointers/banks reset to 0 on the next edge. Any in_valid word in the flush cycle is discarded without setting the error.
- Partial result (FILLING) persists indefinitely until completed or flushed; there is no timeout.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0 (bank storage is cleared), busy=0, overflow_err=0, all pointers 0, all banks EMPTY.
- Reset asserted mid-operation: immediate asynchronous return to the reset values; in-flight data is lost.
- Latency: the Nth word is accepted at edge t; out_valid rises after edge t+1 with word 0, provided the read side is idle.
- Throughput: one word per cycle on both sides. A sustained input with out_ready=1 never overflows.
- out_data and out_last are held stable while out_valid && !out_ready.
- busy falls the cycle after the final out_last handshake when no bank is FILLING.

## Configuration
- PAILLIER_COLLECT_MSW_FIRST_EN:
  - Defined: the read index is N-1-rd_ptr, so words are emitted MSW first. out_last still marks the final emitted word, which is stored word 0.
  - Undefined: LSW-first order, the same order as captured.

## Structure
- paillier_pkg holds:
  - the default K/N localparams;
  - typedef enum bank_state_t {EMPTY, FILLING, FULL, DRAINING};
  - the word type typedef logic [K-1:0] word_t.
- One sub-module is natural: paillier_word_bank, a single N×K register bank with one write port, one combinational read port and a clear. It is instantiated twice.
- Pointer and state control stays in the top.

## Test plan
- Basic frame: 32 words 0x1..0x20 with out_ready=1 → out_valid rises one cycle after word 32. The consumer sees 0x1..0x20 with out_last only on 0x20 and overflow_err=0.
- Ping-pong: two back-to-back frames A (0xA00+i) and B (0xB00+i) with out_ready=1 → 64 words in order and no error. busy=0 one cycle after the last handshake.
- Backpressure overflow: out_ready=0 while 3 frames are sent → frames 1 and 2 are retained and frame 3 is dropped, with overflow_err set on the first word of frame 3. Releasing out_ready then gives 64 words (frames 1, 2); err_clr drops the flag.
- Stall stability: out_ready toggles every cycle → out_data/out_last are unchanged across each stall and the word order is intact.
- Flush mid-fill: 10 words, then flush, then a full frame 0xC00+i → only the 32 C words are output and overflow_err=0.
- Async reset mid-drain: rst asserted while word 5 is being output → out_valid=0 immediately. A new frame after release is output correctly from index 0.
